// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for a single-cycle core.
// Runs an IDLE/RUN/HALT state machine. In RUN it selects the next PC from
// JR, J/JAL, a conditional branch or a fall-through.
// Optional feature macro: PC_SEQ_STAT_COUNTERS_EN enables the RUN-cycle
// and redirect statistics counters. When the macro is undefined, both
// counter outputs are tied to zero.
module pc_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [31:0] instr,
  input  logic [11:0] sg,
  input  logic        equal,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [9:0]  imem_addr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [31:0] link_pc,
  output logic        run_en,
  output logic        halted,
  output logic [31:0] cycle_cnt,
  output logic [31:0] taken_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;

  logic        syscall_s;
  logic        jr_s;
  logic        jump_s;
  logic        branch_taken_s;
  logic        redirect_s;
  logic [31:0] link_pc_s;
  logic [31:0] branch_tgt_s;
  logic [31:0] next_pc_s;

  assign syscall_s      = sg[4];
  assign jr_s           = sg[9];
  assign jump_s         = sg[10];
  // With BEQ and BNE both set, the OR makes the branch unconditionally taken.
  assign branch_taken_s = (sg[7] & equal) | (sg[8] & ~equal);
  assign redirect_s     = jr_s | jump_s | branch_taken_s;

  // Modulo-2^32 arithmetic: 0xFFFFFFFC + 4 wraps to zero.
  assign link_pc_s    = pc_q + 32'd4;
  assign branch_tgt_s = link_pc_s + {{14{instr[15]}}, instr[15:0], 2'b00};

  // Next-PC priority select: JR, then J/JAL, then taken branch, then fall-through.
  always_comb begin
    next_pc_s = link_pc_s;
    if (jr_s) begin
      next_pc_s = {rs_data[31:2], 2'b00};
    end else if (jump_s) begin
      next_pc_s = {link_pc_s[31:28], instr[25:0], 2'b00};
    end else if (branch_taken_s) begin
      next_pc_s = branch_tgt_s;
    end else begin
      next_pc_s = link_pc_s;
    end
  end

  // Next-state and next-PC decode. The PC only moves while in RUN.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (syscall_s) begin
          // SYSCALL wins over a simultaneous go. Resume continues at syscall_pc+4.
          state_d = S_HALT;
          pc_d    = link_pc_s;
        end else begin
          state_d = S_RUN;
          pc_d    = next_pc_s;
        end
      end
      S_HALT: begin
        if (go) begin
          state_d = S_RUN;
        end else begin
          state_d = S_HALT;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = 32'h0000_0000;
      end
    endcase
  end

  // State and PC registers. Reset overrides every other condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PC_SEQ_STAT_COUNTERS_EN
  logic [31:0] cycle_q;
  logic [31:0] taken_q;

  // Statistics counters advance only on RUN edges and wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= 32'd0;
      taken_q <= 32'd0;
    end else if (state_q == S_RUN) begin
      cycle_q <= cycle_q + 32'd1;
      if (redirect_s && !syscall_s) begin
        taken_q <= taken_q + 32'd1;
      end else begin
        taken_q <= taken_q;
      end
    end else begin
      cycle_q <= cycle_q;
      taken_q <= taken_q;
    end
  end

  assign cycle_cnt = cycle_q;
  assign taken_cnt = taken_q;
`else
  assign cycle_cnt = 32'd0;
  assign taken_cnt = 32'd0;
`endif

  // These decoder bits and rs_data[1:0] do not affect sequencing.
  logic unused_s;
  assign unused_s = ^{sg[11], sg[6:5], sg[3:0], rs_data[1:0]};

  assign pc        = pc_q;
  assign imem_addr = pc_q[11:2];
  assign op        = instr[31:26];
  assign funct     = instr[5:0];
  assign link_pc   = link_pc_s;
  assign run_en    = (state_q == S_RUN);
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: table-driven vectors through a
// scoreboard queue, plus hand-written HALT-hold and reset sequences.
// Counter expectations follow PC_SEQ_STAT_COUNTERS_EN.
module tb_pc_sequencer;

  localparam logic [11:0] SG_NONE = 12'h000;
  localparam logic [11:0] SG_SYS  = 12'h010;
  localparam logic [11:0] SG_BEQ  = 12'h080;
  localparam logic [11:0] SG_BNE  = 12'h100;
  localparam logic [11:0] SG_JR   = 12'h200;
  localparam logic [11:0] SG_J    = 12'h400;
  localparam logic [11:0] SG_JAL  = 12'hC00;

  localparam int ST_IDLE = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_HALT = 2;

  logic        clk = 1'b0;
  logic        rst, go, equal;
  logic [31:0] instr, rs_data;
  logic [11:0] sg;
  logic [31:0] pc, link_pc, cycle_cnt, taken_cnt;
  logic [9:0]  imem_addr;
  logic [5:0]  op, funct;
  logic        run_en, halted;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic        rst;
    logic        go;
    logic [31:0] instr;
    logic [11:0] sg;
    logic        equal;
    logic [31:0] rs_data;
    logic [31:0] exp_pc;
    int          exp_st;
    logic [31:0] exp_cyc;
    logic [31:0] exp_tk;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];

  pc_sequencer dut (
    .clk(clk), .rst(rst), .go(go), .instr(instr), .sg(sg), .equal(equal),
    .rs_data(rs_data), .pc(pc), .imem_addr(imem_addr), .op(op), .funct(funct),
    .link_pc(link_pc), .run_en(run_en), .halted(halted),
    .cycle_cnt(cycle_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string tag, input logic r, input logic g,
                              input logic [31:0] ins, input logic [11:0] s,
                              input logic eq, input logic [31:0] rs,
                              input logic [31:0] epc, input int est,
                              input logic [31:0] ecyc, input logic [31:0] etk);
    vec_t v;
    v.tag = tag; v.rst = r; v.go = g; v.instr = ins; v.sg = s; v.equal = eq;
    v.rs_data = rs; v.exp_pc = epc; v.exp_st = est; v.exp_cyc = ecyc; v.exp_tk = etk;
    return v;
  endfunction

  task automatic chk(input string tag, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", tag, name, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare every output against it.
  task automatic check_front();
    vec_t e;
    logic [31:0] e_pc4;
    logic [31:0] e_cyc, e_tk;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb_q.pop_front();
      e_pc4 = e.exp_pc + 32'd4;
`ifdef PC_SEQ_STAT_COUNTERS_EN
      e_cyc = e.exp_cyc;
      e_tk  = e.exp_tk;
`else
      e_cyc = 32'd0;
      e_tk  = 32'd0;
`endif
      chk(e.tag, "pc",        pc,                e.exp_pc);
      chk(e.tag, "run_en",    {31'd0, run_en},   {31'd0, e.exp_st == ST_RUN});
      chk(e.tag, "halted",    {31'd0, halted},   {31'd0, e.exp_st == ST_HALT});
      chk(e.tag, "imem_addr", {22'd0, imem_addr}, {22'd0, e.exp_pc[11:2]});
      chk(e.tag, "link_pc",   link_pc,           e_pc4);
      chk(e.tag, "op",        {26'd0, op},       {26'd0, e.instr[31:26]});
      chk(e.tag, "funct",     {26'd0, funct},    {26'd0, e.instr[5:0]});
      chk(e.tag, "cycle_cnt", cycle_cnt,         e_cyc);
      chk(e.tag, "taken_cnt", taken_cnt,         e_tk);
    end
  endtask

  // Drive one vector, record its expectation, clock once, then compare.
  task automatic apply(input vec_t v);
    rst = v.rst; go = v.go; instr = v.instr; sg = v.sg;
    equal = v.equal; rs_data = v.rs_data;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    check_front();
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; instr = 32'd0; sg = SG_NONE; equal = 1'b0; rs_data = 32'd0;

    //               tag          rst  go   instr          sg              eq   rs_data        pc            state    cyc     tk
    vecs.push_back(mk("reset",    1'b1, 1'b0, 32'h0000_0000, SG_NONE,        1'b0, 32'h0,        32'h0,        ST_IDLE, 32'd0,  32'd0));
    vecs.push_back(mk("idle_sg",  1'b0, 1'b0, 32'h0000_0000, SG_JR,          1'b0, 32'h80,       32'h0,        ST_IDLE, 32'd0,  32'd0));
    vecs.push_back(mk("go",       1'b0, 1'b1, 32'h0000_0000, SG_NONE,        1'b0, 32'h0,        32'h0,        ST_RUN,  32'd0,  32'd0));
    vecs.push_back(mk("nop1",     1'b0, 1'b0, 32'h0000_0000, SG_NONE,        1'b0, 32'h0,        32'h4,        ST_RUN,  32'd1,  32'd0));
    vecs.push_back(mk("nop2",     1'b0, 1'b0, 32'h0000_0000, SG_NONE,        1'b0, 32'h0,        32'h8,        ST_RUN,  32'd2,  32'd0));
    vecs.push_back(mk("nop3",     1'b0, 1'b0, 32'h0000_0000, SG_NONE,        1'b0, 32'h0,        32'hC,        ST_RUN,  32'd3,  32'd0));
    vecs.push_back(mk("nop4",     1'b0, 1'b0, 32'h0000_0000, SG_NONE,        1'b0, 32'h0,        32'h10,       ST_RUN,  32'd4,  32'd0));
    vecs.push_back(mk("beq_tk",   1'b0, 1'b0, 32'h1000_FFFE, SG_BEQ,         1'b1, 32'h0,        32'hC,        ST_RUN,  32'd5,  32'd1));
    vecs.push_back(mk("nop5",     1'b0, 1'b0, 32'h0000_0000, SG_NONE,        1'b0, 32'h0,        32'h10,       ST_RUN,  32'd6,  32'd1));
    vecs.push_back(mk("beq_nt",   1'b0, 1'b0, 32'h1000_FFFE, SG_BEQ,         1'b0, 32'h0,        32'h14,       ST_RUN,  32'd7,  32'd1));
    vecs.push_back(mk("bne_tk",   1'b0, 1'b0, 32'h1400_0003, SG_BNE,         1'b0, 32'h0,        32'h24,       ST_RUN,  32'd8,  32'd2));
    vecs.push_back(mk("beq_bne",  1'b0, 1'b0, 32'h1400_0001, SG_BEQ|SG_BNE,  1'b0, 32'h0,        32'h2C,       ST_RUN,  32'd9,  32'd3));
    vecs.push_back(mk("jr",       1'b0, 1'b0, 32'h0000_0008, SG_JR,          1'b0, 32'h41,       32'h40,       ST_RUN,  32'd10, 32'd4));
    vecs.push_back(mk("jr_over_j",1'b0, 1'b0, 32'h0800_0010, SG_J|SG_JR,     1'b0, 32'h123,      32'h120,      ST_RUN,  32'd11, 32'd5));
    vecs.push_back(mk("j",        1'b0, 1'b0, 32'h0800_0010, SG_J,           1'b0, 32'h123,      32'h40,       ST_RUN,  32'd12, 32'd6));
    vecs.push_back(mk("jal",      1'b0, 1'b0, 32'h0C00_0008, SG_JAL,         1'b0, 32'h0,        32'h20,       ST_RUN,  32'd13, 32'd7));
    vecs.push_back(mk("syscall",  1'b0, 1'b1, 32'h0000_000C, SG_SYS,         1'b0, 32'h0,        32'h24,       ST_HALT, 32'd14, 32'd7));

    foreach (vecs[i]) apply(vecs[i]);

    // HALT must freeze pc for five edges even with every decoder bit set.
    for (int k = 0; k < 5; k++) begin
      apply(mk("halt_hold", 1'b0, 1'b0, 32'h1000_FFFE, 12'hFFF, 1'b1, 32'h200, 32'h24, ST_HALT, 32'd14, 32'd7));
    end
    apply(mk("resume",    1'b0, 1'b1, 32'h0000_0000, SG_NONE, 1'b0, 32'h0,         32'h24,        ST_RUN,  32'd14, 32'd7));
    apply(mk("resume_nx", 1'b0, 1'b0, 32'h0000_0000, SG_NONE, 1'b0, 32'h0,         32'h28,        ST_RUN,  32'd15, 32'd7));

    // Wrap at the top of the address space.
    apply(mk("jr_top",    1'b0, 1'b0, 32'h0000_0008, SG_JR,   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFC, ST_RUN,  32'd16, 32'd8));
    apply(mk("wrap",      1'b0, 1'b0, 32'h0000_0000, SG_NONE, 1'b0, 32'h0,         32'h0,         ST_RUN,  32'd17, 32'd8));

    // Mid-run reset beats go and a redirect; the restart counts from zero.
    apply(mk("rst_run",   1'b1, 1'b1, 32'h0000_0008, SG_JR,   1'b0, 32'h80,        32'h0,         ST_IDLE, 32'd0,  32'd0));
    apply(mk("idle2",     1'b0, 1'b0, 32'h0000_0008, SG_JR,   1'b0, 32'h80,        32'h0,         ST_IDLE, 32'd0,  32'd0));
    apply(mk("go2",       1'b0, 1'b1, 32'h0000_0000, SG_NONE, 1'b0, 32'h0,         32'h0,         ST_RUN,  32'd0,  32'd0));
    apply(mk("nop_rs",    1'b0, 1'b0, 32'h0000_0000, SG_NONE, 1'b0, 32'h0,         32'h4,         ST_RUN,  32'd1,  32'd0));

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
